adc_result_serializer: RTL and testbench

- Readout side of the ADC result path: reads a completed parallel conversion word from the capture registers over a valid/ready handshake.
- Transmits the word MSB-first on a 3-wire serial link (cs_n, sclk, sdata) to the off-chip / host receiver.
- Sits downstream of the SAR bit-capture flops. Generates its own serial clock from the system clock.

---
 rtl/adc_serial_pkg.sv | 21 ++
 rtl/sclk_tick_gen.sv | 32 +++
 rtl/adc_result_serializer.sv | 111 +++++++++++
 tb/tb_adc_result_serializer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_pkg.sv
// Shared definitions for the ADC result serial link: FSM states, default
// geometry and the frame-length helper used by both ends of the link.
package adc_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  localparam int unsigned DEF_DATA_W  = 10;
  localparam int unsigned DEF_CLK_DIV = 4;

  // Number of clk cycles cs_n stays low for one frame.
  function automatic int unsigned frame_cycles(input int unsigned data_w,
                                               input int unsigned clk_div);
    return clk_div * (2 * data_w + 2);
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator for the serial clock: counts CLK_DIV system
// clocks and flags the last one, restarting cleanly at frame start.
module sclk_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter, wraps only on explicit terminal compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == TERM) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/adc_result_serializer.sv
// ADC result serializer: accepts a parallel conversion word over valid/ready
// and sends it MSB-first on a cs_n/sclk/sdata link clocked from clk.
module adc_result_serializer
  import adc_serial_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              cs_n,
  output logic              sclk,
  output logic              sdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t state, next_state;

  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              accept;
  logic              tick;
  logic              last_bit;
  logic              cs_n_nxt;
  logic              sclk_nxt;
  logic              done_nxt;

  assign data_ready = (state == IDLE);
  assign busy       = ~data_ready;
  assign accept     = data_valid && data_ready;
  assign last_bit   = (bit_cnt == LAST_BIT);
  // The shift register's MSB is the line; it is cleared whenever idle.
  assign sdata      = shreg[DATA_W-1];

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (accept),
    .en     (busy),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decode; SHIFT ends on the low-half tick of the last bit.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)                      next_state = SETUP;
      SETUP:   if (tick)                        next_state = SHIFT;
      SHIFT:   if (tick && !sclk && last_bit)   next_state = HOLD;
      HOLD:    if (tick)                        next_state = IDLE;
      default:                                  next_state = IDLE;
    endcase
  end

  // Next values of the registered link outputs.
  always_comb begin
    cs_n_nxt = (next_state == IDLE);
    sclk_nxt = (next_state == SHIFT) ? (sclk ^ tick) : 1'b0;
    done_nxt = (state == HOLD) && (next_state == IDLE);
  end

  // Link output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_n <= 1'b1;
      sclk <= 1'b0;
      done <= 1'b0;
    end else begin
      cs_n <= cs_n_nxt;
      sclk <= sclk_nxt;
      done <= done_nxt;
    end
  end

  // Shift register and bit counter. bit_cnt steps on the rising tick that
  // opens the next bit, so during a bit's low half it still names that bit
  // and the last-bit test needs no lookahead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= data_in;
      bit_cnt <= '0;
    end else if (state == SHIFT && tick) begin
      if (sclk) begin
        if (!last_bit) shreg <= {shreg[DATA_W-2:0], 1'b0};
      end else if (!last_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else if (state == HOLD && tick) begin
      shreg <= '0;
    end
  end

endmodule

// File: tb/tb_adc_result_serializer.sv
// Directed testbench for adc_result_serializer: default geometry instance
// plus a DATA_W=2 / CLK_DIV=1 instance, with a sclk-rising-edge receiver.
module tb_adc_result_serializer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready, cs_n, sclk, sdata, busy, done;

  logic [1:0] d2_in = '0;
  logic       v2 = 1'b0;
  logic       ready2, cs2_n, sclk2, sdata2, busy2, done2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_result_serializer #(
    .DATA_W (10),
    .CLK_DIV(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .sdata     (sdata),
    .busy      (busy),
    .done      (done)
  );

  adc_result_serializer #(
    .DATA_W (2),
    .CLK_DIV(1)
  ) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (d2_in),
    .data_valid(v2),
    .data_ready(ready2),
    .cs_n      (cs2_n),
    .sclk      (sclk2),
    .sdata     (sdata2),
    .busy      (busy2),
    .done      (done2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: drop valid after accept
  // mode 1: hold valid, zero data_in at T0+1, drop valid in the done cycle
  // mode 2: hold valid, present next_w in the done cycle (back-to-back)
  task automatic run_frame(input string tag, input logic [9:0] w,
                           input bit present, input int mode,
                           input logic [9:0] next_w);
    logic [9:0] got;
    int  low, rises, done_at;
    bit  prev_sclk, ready_bad;
    got = '0; low = 0; rises = 0; done_at = 0; prev_sclk = 1'b0; ready_bad = 1'b0;
    if (present) begin
      @(negedge clk);
      data_in    = w;
      data_valid = 1'b1;
    end
    check_eq({tag, "_ready_T0"}, 32'(data_ready), 32'd1);
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check_eq({tag, "_csn_T0+1"}, 32'(cs_n), 32'd0);
        check_eq({tag, "_msb_T0+1"}, 32'(sdata), 32'(w[9]));
        if (mode == 1) data_in = '0;
        else if (mode == 0) data_valid = 1'b0;
      end
      if (!cs_n) low++;
      if (sclk && !prev_sclk) begin
        rises++;
        got = {got[8:0], sdata};
      end
      prev_sclk = sclk;
      if (done) begin
        done_at = n;
        break;
      end
      if (data_ready || !busy) ready_bad = 1'b1;
    end
    check_eq({tag, "_bits"}, 32'(got), 32'(w));
    check_eq({tag, "_cs_low"}, 32'(low), 32'd88);
    check_eq({tag, "_sclk_rises"}, 32'(rises), 32'd10);
    check_eq({tag, "_done_at"}, 32'(done_at), 32'd89);
    check_eq({tag, "_busy_in_frame"}, 32'(ready_bad), 32'd0);
    check_eq({tag, "_done_ready"}, 32'(data_ready), 32'd1);
    check_eq({tag, "_done_csn"}, 32'(cs_n), 32'd1);
    check_eq({tag, "_done_sclk_sdata"}, 32'({sclk, sdata, busy}), 32'd0);
    if (mode == 2) begin
      data_in    = next_w;
      data_valid = 1'b1;
    end else begin
      data_valid = 1'b0;
    end
    if (mode == 1) begin
      @(negedge clk);
      check_eq({tag, "_no_reaccept"}, 32'({cs_n, data_ready, done}), 32'b110);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit idle_bad, done_seen;
    logic [1:0] got2;
    int low2, rises2, done2_at, r1, r2;
    bit prev2;

    // Reset state, then a long idle stretch.
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", 32'({data_ready, cs_n, sclk, sdata, busy, done}), 32'b110000);
    reset_n = 1'b1;
    idle_bad = 1'b0; done_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ({data_ready, cs_n, sclk, sdata, busy} !== 5'b11000) idle_bad = 1'b1;
      if (done !== 1'b0 || done2 !== 1'b0) done_seen = 1'b1;
    end
    check_eq("idle_levels", 32'(idle_bad), 32'd0);
    check_eq("idle_no_done", 32'(done_seen), 32'd0);

    // Single frame at defaults.
    run_frame("single", 10'h2B5, 1'b1, 0, 10'h000);
    repeat (3) @(negedge clk);

    // Valid held and data_in changed mid-frame.
    run_frame("hold", 10'h2B5, 1'b1, 1, 10'h000);
    repeat (3) @(negedge clk);

    // Back-to-back frames; second frame checks cs_n low right after done.
    run_frame("b2b_a", 10'h3FF, 1'b1, 2, 10'h001);
    run_frame("b2b_b", 10'h001, 1'b0, 0, 10'h000);
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame.
    @(negedge clk);
    data_in = 10'h2B5; data_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) data_valid = 1'b0;
    end
    check_eq("mid_frame_active", 32'(cs_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check_eq("abort_outputs", 32'({cs_n, sclk, sdata, done, data_ready}), 32'b10001);
    done_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || !cs_n) done_seen = 1'b1;
    end
    check_eq("abort_no_done", 32'(done_seen), 32'd0);
    run_frame("after_rst", 10'h155, 1'b1, 0, 10'h000);

    // Minimum geometry: DATA_W=2, CLK_DIV=1.
    got2 = '0; low2 = 0; rises2 = 0; done2_at = 0; r1 = 0; r2 = 0; prev2 = 1'b0;
    @(negedge clk);
    d2_in = 2'b10; v2 = 1'b1;
    check_eq("small_ready_T0", 32'(ready2), 32'd1);
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) v2 = 1'b0;
      if (!cs2_n) low2++;
      if (sclk2 && !prev2) begin
        rises2++;
        if (rises2 == 1) r1 = n;
        if (rises2 == 2) r2 = n;
        got2 = {got2[0], sdata2};
      end
      prev2 = sclk2;
      if (done2) begin
        done2_at = n;
        break;
      end
    end
    check_eq("small_cs_low", 32'(low2), 32'd6);
    check_eq("small_bits", 32'(got2), 32'b10);
    check_eq("small_rises", 32'(rises2), 32'd2);
    check_eq("small_sclk_period", 32'(r2 - r1), 32'd2);
    check_eq("small_done_at", 32'(done2_at), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
